// File: rtl/cp0_timer_ext.sv
// cp0_timer_ext: second-generation coprocessor-0 for the pipelined MIPS core.
// Holds SR/Cause/EPC together with a prescaled Count/Compare timer, BadVAddr
// capture, two software interrupts, N_HW hardware interrupt lines and a
// highest-priority pending-interrupt index.
//
// Ports:
//   clk              core clock
//   reset            synchronous active-low reset
//   ReadAddr[4:0]    MFC0 register select
//   WrAddr[4:0]      MTC0 register select
//   CP0Wr            MTC0 write enable
//   CP0_IN[31:0]     MTC0 data
//   HWInt[N_HW-1:0]  level-sensitive external interrupt lines
//   ext_int_control  01 exception entry (BEGIN), 10 ERET (END), else none
//   Ext_code[4:0]    ExcCode captured on BEGIN
//   BDop             victim instruction sits in a delay slot
//   PC[31:0]         victim PC
//   BadAddr[31:0]    faulting address
//   IntReq           interrupt request to the pipeline
//   int_idx[2:0]     highest pending enabled IP index, 0 when none
//   EPC_OUT[31:0]    current EPC
//   CP0_OUT[31:0]    MFC0 read data (no write bypass)
//   EXL_val          current EXL
module cp0_timer_ext #(
  parameter int          N_HW      = 6,
  parameter int          COUNT_DIV = 2,
  parameter int          TIMER_IP  = 7,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4E59
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ReadAddr,
  input  logic [4:0]      WrAddr,
  input  logic            CP0Wr,
  input  logic [31:0]     CP0_IN,
  input  logic [N_HW-1:0] HWInt,
  input  logic [1:0]      ext_int_control,
  input  logic [4:0]      Ext_code,
  input  logic            BDop,
  input  logic [31:0]     PC,
  input  logic [31:0]     BadAddr,
  output logic            IntReq,
  output logic [2:0]      int_idx,
  output logic [31:0]     EPC_OUT,
  output logic [31:0]     CP0_OUT,
  output logic            EXL_val
);

  localparam int             PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE = PW'(1);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // Index of the most significant set bit; 0 when the vector is empty.
  function automatic logic [2:0] highest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  logic [31:0]     epc_r;
  logic [31:0]     badvaddr_r;
  logic [31:0]     count_r;
  logic [31:0]     compare_r;
  logic [PW-1:0]   presc_r;
  logic [7:0]      im_r;
  logic            ie_r;
  logic            exl_r;
  logic            bd_r;
  logic [1:0]      swip_r;
  logic [N_HW-1:0] hwip_r;
  logic [4:0]      exccode_r;
  logic            ti_r;

  logic            begin_s;
  logic            end_s;
  logic            wr_count_s;
  logic            wr_compare_s;
  logic            wr_sr_s;
  logic            wr_cause_s;
  logic            wr_epc_s;
  logic            tick_s;
  logic [31:0]     count_inc_s;
  logic [7:0]      ip_s;
  logic [7:0]      pend_s;
  logic [31:0]     rdata_s;

  assign begin_s      = (ext_int_control == 2'b01);
  assign end_s        = (ext_int_control == 2'b10);
  assign wr_count_s   = CP0Wr && (WrAddr == ADDR_COUNT);
  assign wr_compare_s = CP0Wr && (WrAddr == ADDR_COMPARE);
  assign wr_sr_s      = CP0Wr && (WrAddr == ADDR_SR);
  assign wr_cause_s   = CP0Wr && (WrAddr == ADDR_CAUSE);
  assign wr_epc_s     = CP0Wr && (WrAddr == ADDR_EPC);
  assign tick_s       = (presc_r == PRESC_MAX);
  assign count_inc_s  = count_r + 32'd1;

  // Prescaler, Count and Compare; a Compare write clears TI even if a match lands in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r   <= '0;
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      if (wr_count_s) begin
        count_r <= CP0_IN;
        presc_r <= '0;
      end else if (tick_s) begin
        count_r <= count_inc_s;
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PRESC_ONE;
      end
      if (wr_compare_s) begin
        compare_r <= CP0_IN;
        ti_r      <= 1'b0;
      end else if (!wr_count_s && tick_s && (count_inc_s == compare_r)) begin
        ti_r <= 1'b1;
      end
    end
  end

  // SR: IM/IE always follow MTC0; EXL is owned by BEGIN/END before MTC0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_r  <= 8'h00;
      ie_r  <= 1'b0;
      exl_r <= 1'b0;
    end else begin
      if (wr_sr_s) begin
        im_r <= CP0_IN[15:8];
        ie_r <= CP0_IN[0];
      end
      if (begin_s) begin
        exl_r <= 1'b1;
      end else if (end_s) begin
        exl_r <= 1'b0;
      end else if (wr_sr_s) begin
        exl_r <= CP0_IN[1];
      end
    end
  end

  // Cause: SWIP via MTC0, HW lines sampled every cycle, BD/ExcCode with BEGIN taking priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      swip_r    <= 2'b00;
      hwip_r    <= '0;
      bd_r      <= 1'b0;
      exccode_r <= 5'd0;
    end else begin
      hwip_r <= HWInt;
      if (wr_cause_s) begin
        swip_r <= CP0_IN[9:8];
      end
      if (begin_s) begin
        bd_r      <= BDop;
        exccode_r <= Ext_code;
      end else if (wr_cause_s) begin
        bd_r      <= CP0_IN[31];
        exccode_r <= CP0_IN[6:2];
      end
    end
  end

  // EPC and BadVAddr capture; BadVAddr only latches on address-error codes (AdEL=4, AdES=5).
  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_r      <= 32'd0;
      badvaddr_r <= 32'd0;
    end else begin
      if (begin_s) begin
        epc_r <= BDop ? (PC - 32'd4) : PC;
      end else if (wr_epc_s) begin
        epc_r <= CP0_IN;
      end
      if (begin_s && ((Ext_code == 5'd4) || (Ext_code == 5'd5))) begin
        badvaddr_r <= BadAddr;
      end
    end
  end

  // Cause.IP composition: SWIP low, HW lines from bit 2, timer ORed into its IP bit.
  always_comb begin
    ip_s           = 8'h00;
    ip_s[1:0]      = swip_r;
    ip_s[2 +: N_HW] = hwip_r;
    ip_s[TIMER_IP] = ip_s[TIMER_IP] | ti_r;
  end

  assign pend_s  = ip_s & im_r;
  assign IntReq  = (|pend_s) & ie_r & ~exl_r;
  assign int_idx = highest_idx(pend_s);
  assign EPC_OUT = epc_r;
  assign EXL_val = exl_r;

  // MFC0 read mux from register state only.
  always_comb begin
    rdata_s = 32'd0;
    case (ReadAddr)
      ADDR_BADVADDR: rdata_s = badvaddr_r;
      ADDR_COUNT:    rdata_s = count_r;
      ADDR_COMPARE:  rdata_s = compare_r;
      ADDR_SR:       rdata_s = {16'h0000, im_r, 6'b000000, exl_r, ie_r};
      ADDR_CAUSE:    rdata_s = {bd_r, 15'h0000, ip_s, 1'b0, exccode_r, 2'b00};
      ADDR_EPC:      rdata_s = {epc_r[31:2], 2'b00};
      ADDR_PRID:     rdata_s = PRID_VAL;
      default:       rdata_s = 32'd0;
    endcase
  end

  assign CP0_OUT = rdata_s;

endmodule

// File: tb/tb_cp0_timer_ext.sv
`timescale 1ns/1ps
module tb_cp0_timer_ext;

  localparam int          N_HW      = 6;
  localparam int          COUNT_DIV = 2;
  localparam int          TIMER_IP  = 7;
  localparam logic [31:0] PRID      = 32'h0000_4E59;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      ReadAddr, WrAddr;
  logic            CP0Wr;
  logic [31:0]     CP0_IN;
  logic [N_HW-1:0] HWInt;
  logic [1:0]      ext_int_control;
  logic [4:0]      Ext_code;
  logic            BDop;
  logic [31:0]     PC, BadAddr;
  logic            IntReq;
  logic [2:0]      int_idx;
  logic [31:0]     EPC_OUT, CP0_OUT;
  logic            EXL_val;

  int checks   = 0;
  int failures = 0;

  cp0_timer_ext #(.N_HW(N_HW), .COUNT_DIV(COUNT_DIV), .TIMER_IP(TIMER_IP), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .ReadAddr(ReadAddr), .WrAddr(WrAddr), .CP0Wr(CP0Wr),
    .CP0_IN(CP0_IN), .HWInt(HWInt), .ext_int_control(ext_int_control), .Ext_code(Ext_code),
    .BDop(BDop), .PC(PC), .BadAddr(BadAddr), .IntReq(IntReq), .int_idx(int_idx),
    .EPC_OUT(EPC_OUT), .CP0_OUT(CP0_OUT), .EXL_val(EXL_val)
  );

  always #5 clk = ~clk;

  // reference model state (architectural view of CP0)
  logic [31:0]     m_epc, m_bva, m_count, m_cmp;
  int              m_pre;
  logic [7:0]      m_im;
  logic            m_ie, m_exl, m_bd, m_ti;
  logic [1:0]      m_swip;
  logic [N_HW-1:0] m_hw;
  logic [4:0]      m_exc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = 8'h00;
    ip[1:0] = m_swip;
    for (int i = 0; i < N_HW; i++) ip[2+i] = m_hw[i];
    if (m_ti) ip[TIMER_IP] = 1'b1;
    return ip;
  endfunction

  function automatic logic [2:0] m_idx();
    logic [7:0] p;
    p = m_ip() & m_im;
    for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {m_bd, 15'h0, m_ip(), 1'b0, m_exc, 2'b00};
      5'd14:   return m_epc & 32'hFFFF_FFFC;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all();
    logic exp_req;
    exp_req = (|(m_ip() & m_im)) && m_ie && !m_exl;
    check_val("intreq", {31'd0, IntReq}, {31'd0, exp_req});
    check_val("int_idx", {29'd0, int_idx}, {29'd0, m_idx()});
    check_val("epc_out", EPC_OUT, m_epc);
    check_val("exl_val", {31'd0, EXL_val}, {31'd0, m_exl});
    check_val("cp0_out", CP0_OUT, m_read(ReadAddr));
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_update();
    logic [31:0] n_epc, n_bva, n_count, n_cmp;
    int          n_pre;
    logic [7:0]  n_im;
    logic        n_ie, n_exl, n_bd, n_ti, match;
    logic [1:0]  n_swip;
    logic [4:0]  n_exc;
    if (!reset) begin
      m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0; m_pre = 0; m_im = 0; m_ie = 0;
      m_exl = 0; m_bd = 0; m_ti = 0; m_swip = 0; m_hw = 0; m_exc = 0;
      return;
    end
    n_epc = m_epc; n_bva = m_bva; n_count = m_count; n_cmp = m_cmp; n_pre = m_pre;
    n_im = m_im; n_ie = m_ie; n_exl = m_exl; n_bd = m_bd; n_ti = m_ti;
    n_swip = m_swip; n_exc = m_exc; match = 1'b0;
    if (CP0Wr && WrAddr == 5'd9) begin
      n_count = CP0_IN; n_pre = 0;
    end else if (m_pre == COUNT_DIV - 1) begin
      n_pre = 0; n_count = m_count + 32'd1; match = (n_count == m_cmp);
    end else begin
      n_pre = m_pre + 1;
    end
    if (CP0Wr && WrAddr == 5'd11) begin
      n_cmp = CP0_IN; n_ti = 1'b0;
    end else if (match) begin
      n_ti = 1'b1;
    end
    if (CP0Wr && WrAddr == 5'd12) begin
      n_im = CP0_IN[15:8]; n_ie = CP0_IN[0]; n_exl = CP0_IN[1];
    end
    if (CP0Wr && WrAddr == 5'd13) begin
      n_swip = CP0_IN[9:8]; n_bd = CP0_IN[31]; n_exc = CP0_IN[6:2];
    end
    if (CP0Wr && WrAddr == 5'd14) n_epc = CP0_IN;
    if (ext_int_control == 2'b10) n_exl = 1'b0;
    if (ext_int_control == 2'b01) begin
      n_exl = 1'b1; n_exc = Ext_code; n_bd = BDop;
      n_epc = BDop ? PC - 32'd4 : PC;
      if (Ext_code == 5'd4 || Ext_code == 5'd5) n_bva = BadAddr;
    end
    m_epc = n_epc; m_bva = n_bva; m_count = n_count; m_cmp = n_cmp; m_pre = n_pre;
    m_im = n_im; m_ie = n_ie; m_exl = n_exl; m_bd = n_bd; m_ti = n_ti;
    m_swip = n_swip; m_exc = n_exc; m_hw = HWInt;
  endtask

  // check mid-cycle, clock, update model, settle
  task automatic cyc();
    #3;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    CP0Wr = 1'b1; WrAddr = a; CP0_IN = d;
    cyc();
    CP0Wr = 1'b0;
  endtask

  initial begin
    logic [4:0] rd_list [8];
    rd_list = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0; m_pre = 0; m_im = 0; m_ie = 0;
    m_exl = 0; m_bd = 0; m_ti = 0; m_swip = 0; m_hw = 0; m_exc = 0;

    // reset held with everything else active
    reset = 1'b0; HWInt = '1; CP0Wr = 1'b1; WrAddr = 5'd12; CP0_IN = 32'hFFFF_FFFF;
    ext_int_control = 2'b01; Ext_code = 5'd4; BDop = 1'b1; PC = 32'h1234; BadAddr = 32'hFF;
    ReadAddr = 5'd12;
    @(posedge clk); #1;
    cyc(); cyc();
    check_val("rst_intreq", {31'd0, IntReq}, 32'd0);
    check_val("rst_exl", {31'd0, EXL_val}, 32'd0);
    check_val("rst_epc", EPC_OUT, 32'd0);
    check_val("rst_idx", {29'd0, int_idx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      ReadAddr = rd_list[i];
      cyc();
      check_val("rst_read", CP0_OUT, (rd_list[i] == 5'd15) ? PRID : 32'd0);
    end
    reset = 1'b1; CP0Wr = 1'b0; HWInt = '0; ext_int_control = 2'b00;

    // hardware interrupt
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; ReadAddr = 5'd13;
    #1;
    check_val("hw_prelat", {31'd0, IntReq}, 32'd0);
    cyc();
    check_val("hw_intreq", {31'd0, IntReq}, 32'd1);
    check_val("hw_idx", {29'd0, int_idx}, 32'd4);
    check_val("hw_cause", CP0_OUT, 32'h0000_1000);

    // exception entry then ERET
    ext_int_control = 2'b01; BDop = 1'b1; PC = 32'h0000_3008; Ext_code = 5'd5; BadAddr = 32'h13;
    cyc();
    ext_int_control = 2'b00;
    check_val("exc_epc", EPC_OUT, 32'h0000_3004);
    check_val("exc_intreq", {31'd0, IntReq}, 32'd0);
    check_val("exc_exl", {31'd0, EXL_val}, 32'd1);
    check_val("exc_cause", CP0_OUT, 32'h8000_1014);
    ReadAddr = 5'd8; #1;
    check_val("exc_badva", CP0_OUT, 32'h13);
    ext_int_control = 2'b10;
    cyc();
    ext_int_control = 2'b00;
    check_val("eret_exl", {31'd0, EXL_val}, 32'd0);
    check_val("eret_intreq", {31'd0, IntReq}, 32'd1);

    // timer: TI six cycles after the Count write
    HWInt = '0;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd3);
    mtc0(5'd12, 32'h0000_8001);
    cyc(); cyc(); cyc();
    check_val("tmr_early", {31'd0, IntReq}, 32'd0);
    cyc();
    check_val("tmr_intreq", {31'd0, IntReq}, 32'd1);
    check_val("tmr_idx", {29'd0, int_idx}, 32'd7);
    mtc0(5'd11, 32'hFFFF_0000);
    check_val("tmr_clear", {31'd0, IntReq}, 32'd0);

    // Count wrap matches Compare=0
    mtc0(5'd9, 32'hFFFF_FFFF);
    mtc0(5'd11, 32'd0);
    ReadAddr = 5'd9;
    cyc();
    check_val("wrap_count", CP0_OUT, 32'd0);
    ReadAddr = 5'd13; #1;
    check_val("wrap_ti", {31'd0, CP0_OUT[15]}, 32'd1);
    mtc0(5'd11, 32'h7000_0000);

    // BEGIN beats MTC0 EPC; SWIP raises interrupt 0
    ext_int_control = 2'b01; BDop = 1'b0; PC = 32'h100; Ext_code = 5'd0;
    mtc0(5'd14, 32'h200);
    ext_int_control = 2'b00;
    check_val("cfl_epc", EPC_OUT, 32'h100);
    ext_int_control = 2'b10; cyc(); ext_int_control = 2'b00;
    mtc0(5'd12, 32'h0000_0101);
    mtc0(5'd13, 32'h0000_0100);
    check_val("swi_idx", {29'd0, int_idx}, 32'd0);
    check_val("swi_intreq", {31'd0, IntReq}, 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 99) != 0);
      CP0Wr           = ($urandom_range(0, 2) == 0);
      WrAddr          = $urandom_range(0, 1) ? 5'($urandom_range(8, 15)) : 5'($urandom_range(0, 31));
      CP0_IN          = $urandom;
      if (WrAddr == 5'd11 && $urandom_range(0, 1) == 1) CP0_IN = m_count + 32'($urandom_range(1, 4));
      if (WrAddr == 5'd9 && $urandom_range(0, 1) == 1) CP0_IN = m_cmp - 32'($urandom_range(1, 3));
      ReadAddr        = $urandom_range(0, 3) != 0 ? 5'($urandom_range(8, 15)) : 5'($urandom_range(0, 31));
      HWInt           = N_HW'($urandom);
      ext_int_control = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      Ext_code        = 5'($urandom_range(0, 7));
      BDop            = 1'($urandom);
      PC              = $urandom;
      BadAddr         = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
